// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcode constants and hazard-controller state encoding shared by the pipeline.
package cpu_ctrl_pkg;
    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_FADD = 6'h11;
    localparam logic [5:0] OP_FMUL = 6'h12;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    typedef enum logic [1:0] {RUN = 2'd0, FP_WAIT = 2'd1, FLUSH = 2'd2} ctrl_state_t;
endpackage

// File: rtl/stall_counter.sv
// stall_counter: 16-bit saturating event counter with enable and synchronous active-low clear.
module stall_counter (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        enable,
    output logic [15:0] count
);
    always_ff @(posedge clock)
        if (!clear_n) count <= '0;
        else if (enable && count != 16'hFFFF) count <= count + 16'd1;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use stall, branch flush and optional multicycle FP multiply hold.
// Define FP_MULTICYCLE_EN to make FMUL occupy execute for FP_MUL_LAT cycles.
module pipeline_hazard_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int FP_MUL_LAT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  opcode_id,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic [5:0]  opcode_ex,
    input  logic [4:0]  rd_ex,
    input  logic        register_we_ex,
    input  logic        branch,
    input  logic        jump,
    output logic        stall_if,
    output logic        bubble_ex,
    output logic        hold_ex,
    output logic        flush_id,
    output logic [1:0]  ctrl_state,
    output logic [15:0] stall_cycles
);
    ctrl_state_t state;
    logic [3:0]  fp_count;
    logic        load_use, fp_start, fp_stall, unused_id;
    assign unused_id = ^opcode_id;
    assign load_use = state == RUN && opcode_ex == OP_LW && register_we_ex && rd_ex != 5'd0 &&
                      (rd_ex == rs1_id || rd_ex == rs2_id);
`ifdef FP_MULTICYCLE_EN
    assign fp_start = state == RUN && opcode_ex == OP_FMUL;
    assign fp_stall = fp_start || (state == FP_WAIT && fp_count != 4'd0);
`else
    assign fp_start = 1'b0;
    assign fp_stall = 1'b0;
`endif
    assign stall_if   = load_use || fp_stall;
    assign bubble_ex  = load_use;
    assign hold_ex    = fp_stall;
    assign flush_id   = state == FLUSH;
    assign ctrl_state = state;
    // The counter reaches zero on the same edge that returns to RUN, so FP_WAIT lasts FP_MUL_LAT-1 cycles.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= RUN;
            fp_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (fp_start) begin
                        state    <= FP_WAIT;
                        fp_count <= 4'(FP_MUL_LAT - 1);
                    end else if ((branch || jump) && !stall_if) state <= FLUSH;
                end
                FP_WAIT: begin
                    fp_count <= fp_count - 4'd1;
                    if (fp_count <= 4'd1) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
    stall_counter u_stall_counter (
        .clock   (clock),
        .clear_n (reset),
        .enable  (stall_if),
        .count   (stall_cycles)
    );
endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter FP_MUL_LAT, default 3, SHALL set FP multiply EX occupancy in cycles; legal range 2..15.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous, active-low; sampled on the rising edge of clock.
REQ-004 opcode_id  input  6  SHALL carry the opcode of the instruction in decode (IR output).
REQ-005 rs1_id, rs2_id  input  5 each  SHALL carry the decode-stage source register indices.
REQ-006 opcode_ex  input  6  SHALL carry the opcode in execute (first delay stage).
REQ-007 rd_ex  input  5; register_we_ex  input  1  SHALL carry the execute-stage destination and write enable.
REQ-008 branch, jump  input  1 each  SHALL indicate a taken branch/jump resolved in decode.
REQ-009 stall_if  output  1  SHALL hold PC and instruction register when high.
REQ-010 bubble_ex  output  1  SHALL force a NOP (register_we=0, data_we=0) into the execute delay stage when high.
REQ-011 hold_ex  output  1  SHALL freeze the execute delay stage and its operands when high.
REQ-012 flush_id  output  1  SHALL replace the decode-stage instruction with a NOP when high.
REQ-013 ctrl_state  output  2  SHALL expose the FSM state (RUN=0, FP_WAIT=1, FLUSH=2).
REQ-014 stall_cycles  output  16  SHALL count cycles with stall_if high.

Function
REQ-015 Load-use hazard: in RUN, opcode_ex==OP_LW, register_we_ex==1, rd_ex!=0 and rd_ex equal to rs1_id or rs2_id SHALL assert stall_if and bubble_ex combinationally in that same cycle.
REQ-016 A load-use stall SHALL last exactly one cycle; afterwards existing memory bypass supplies the operand.
REQ-017 In RUN, a taken branch or jump with no stall condition active SHALL transition to FLUSH.
REQ-018 FLUSH SHALL assert flush_id for exactly one cycle and then return to RUN; a new branch in FLUSH SHALL be ignored because the flushed slot is a NOP.
REQ-019 Branch or jump raised while stall_if is high SHALL be ignored; decode is held and re-evaluates it after release.
REQ-020 Priority SHALL be: reset > FP_WAIT > load-use stall > branch/jump.
REQ-021 All outputs other than REQ-015 signals SHALL be registered-state decodes; no output depends on opcode_ex except through REQ-015 and REQ-024.
REQ-022 stall_cycles SHALL increment by one on every cycle with stall_if high and SHALL saturate at 16'hFFFF.

Reset
REQ-023 With reset low at a clock edge: ctrl_state=RUN, FP counter=0, stall_cycles=0; stall_if, bubble_ex, hold_ex, flush_id SHALL be 0 in the following cycle, including when reset arrives mid FP_WAIT or FLUSH.

Configuration
REQ-024 With FP_MULTICYCLE_EN defined: in RUN, opcode_ex==OP_FMUL SHALL load the counter with FP_MUL_LAT-1 and enter FP_WAIT; stall_if and hold_ex SHALL be high in the detection cycle and in every FP_WAIT cycle while counter!=0; counter decrements each cycle; counter==0 returns to RUN with stall_if and hold_ex low.
REQ-025 Total FP_MUL execute occupancy SHALL equal FP_MUL_LAT cycles; a load-use hazard pending at FP_WAIT exit SHALL be evaluated in the first RUN cycle.
REQ-026 Without FP_MULTICYCLE_EN: FP_WAIT SHALL be unreachable, hold_ex SHALL be tied 0, and FP_MUL SHALL be treated as single-cycle.

Structure
REQ-027 Package cpu_ctrl_pkg SHALL hold opcode constants (OP_LW, OP_SW, OP_FMUL, OP_FADD, OP_BEQ, OP_J) and the ctrl_state encoding; the pipeline top SHALL import the same package.
REQ-028 The saturating counter SHALL be a sub-module named stall_counter (16-bit, enable, synchronous active-low clear).

Verification
REQ-029 LW r5 in EX, decode ADD r6,r5,r2 -> stall_if=1, bubble_ex=1 for 1 cycle; stall_cycles 0->1.
REQ-030 LW r0 in EX, decode uses r0 -> no stall; LW r5 with register_we_ex=0 -> no stall.
REQ-031 Macro defined, FP_MUL_LAT=3, FMUL in EX -> stall_if/hold_ex high for 3 cycles, ctrl_state 0,1,1,0; stall_cycles +3.
REQ-032 branch=1 in RUN -> ctrl_state=FLUSH and flush_id=1 next cycle only; branch=1 during load-use stall -> no flush.
REQ-033 Reset low during FP_WAIT second cycle -> next cycle ctrl_state=0, all controls 0, stall_cycles=0.
REQ-034 Force 65536 stall cycles -> stall_cycles holds 16'hFFFF; macro undefined with FMUL in EX -> hold_ex stays 0.
